// File: rtl/mem_fill_arbiter.sv
// Shares one fixed-latency memory port between the I-cache fill path and the D-cache fill/write path.
// Grants one side at a time and sequences a pipelined block fill or a single-word write.
module mem_fill_arbiter #(
    parameter int MEM_LAT   = 4,
    parameter int BLK_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_req,
    input  logic [15:0]                  i_addr,
    output logic                         i_grant,
    output logic                         i_done,
    input  logic                         d_req,
    input  logic                         d_wr,
    input  logic [15:0]                  d_addr,
    input  logic [15:0]                  d_wdata,
    output logic                         d_grant,
    output logic                         d_done,
    output logic                         fill_vld,
    output logic [$clog2(BLK_WORDS)-1:0] fill_idx,
    output logic [15:0]                  fill_data,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [15:0]                  mem_addr,
    output logic [15:0]                  mem_wdata,
    input  logic [15:0]                  mem_rdata,
    input  logic                         mem_vld
);
    localparam int IW = $clog2(BLK_WORDS);
    localparam int BW = 16 - IW - 1;
    localparam int AW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   iss_cnt_q, iss_cnt_d;
    logic [IW-1:0]   ret_cnt_q, ret_cnt_d;
    logic            iss_act_q, iss_act_d;
    logic [BW-1:0]   base_q, base_d;
    logic [AW-1:0]   age_q, age_d;
    logic            last_d_q, last_d_d;
    logic            i_done_q, i_done_d;
    logic            d_done_q, d_done_d;
    logic            armed;
    logic            unused_addr_bits;

    // Offset bits of the I address are implied by the block walk.
    assign unused_addr_bits = ^i_addr[IW:0];

    // Returns are only accepted MEM_LAT cycles into a fill, so stale data from an
    // aborted transaction can never be counted as part of a new one.
    assign armed = (age_q == AW'(MEM_LAT));

    assign i_grant = (state_q == I_FILL);
    assign d_grant = (state_q == D_FILL) || (state_q == D_WRITE);
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;

    always_comb begin
        state_d   = state_q;
        iss_cnt_d = iss_cnt_q;
        iss_act_d = iss_act_q;
        ret_cnt_d = ret_cnt_q;
        base_d    = base_q;
        age_d     = age_q;
        last_d_d  = last_d_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_vld  = 1'b0;
        fill_idx  = '0;
        fill_data = '0;
        case (state_q)
            IDLE: begin
                iss_cnt_d = '0;
                ret_cnt_d = '0;
                age_d     = '0;
                iss_act_d = 1'b0;
                // D wins a tie unless D owned the last completed transaction.
                if (d_req && (!i_req || !last_d_q)) begin
                    if (d_wr) begin
                        state_d = D_WRITE;
                    end else begin
                        state_d   = D_FILL;
                        base_d    = d_addr[15:IW+1];
                        iss_act_d = 1'b1;
                    end
                end else if (i_req) begin
                    state_d   = I_FILL;
                    base_d    = i_addr[15:IW+1];
                    iss_act_d = 1'b1;
                end
            end
            I_FILL, D_FILL: begin
                if (!armed) age_d = age_q + 1'b1;
                if (iss_act_q) begin
                    mem_en    = 1'b1;
                    mem_addr  = {base_q, iss_cnt_q, 1'b0};
                    iss_cnt_d = iss_cnt_q + 1'b1;
                    if (iss_cnt_q == IW'(BLK_WORDS - 1)) iss_act_d = 1'b0;
                end
                fill_idx  = ret_cnt_q;
                fill_data = mem_rdata;
                if (mem_vld && armed) begin
                    fill_vld  = 1'b1;
                    ret_cnt_d = ret_cnt_q + 1'b1;
                    if (ret_cnt_q == IW'(BLK_WORDS - 1)) begin
                        state_d = IDLE;
                        if (state_q == I_FILL) begin
                            i_done_d = 1'b1;
                            last_d_d = 1'b0;
                        end else begin
                            d_done_d = 1'b1;
                            last_d_d = 1'b1;
                        end
                    end
                end
            end
            D_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                state_d   = IDLE;
                d_done_d  = 1'b1;
                last_d_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            iss_cnt_q <= '0;
            iss_act_q <= 1'b0;
            ret_cnt_q <= '0;
            base_q    <= '0;
            age_q     <= '0;
            last_d_q  <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            iss_cnt_q <= iss_cnt_d;
            iss_act_q <= iss_act_d;
            ret_cnt_q <= ret_cnt_d;
            base_q    <= base_d;
            age_q     <= age_d;
            last_d_q  <= last_d_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
        end
    end
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: fixed-latency memory model, expected-queue scoreboard,
// a vector table of single transactions and hand-written arbitration/reset sequences.
module tb_mem_fill_arbiter;
    localparam int MEM_LAT   = 4;
    localparam int BLK_WORDS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_grant, i_done, d_grant, d_done, fill_vld;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr, mem_vld;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_addr_q[$];
    logic [18:0] exp_fill_q[$];
    logic [31:0] exp_wr_q[$];

    always #5 clk = ~clk;

    mem_fill_arbiter #(.MEM_LAT(MEM_LAT), .BLK_WORDS(BLK_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_done(d_done),
        .fill_vld(fill_vld), .fill_idx(fill_idx), .fill_data(fill_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_vld(mem_vld)
    );

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Memory model: read data appears MEM_LAT cycles after the strobe.
    logic        pv[MEM_LAT] = '{default: 1'b0};
    logic [15:0] pa[MEM_LAT] = '{default: 16'h0};
    always @(posedge clk) begin
        pv[0] <= mem_en && !mem_wr;
        pa[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign mem_vld   = pv[MEM_LAT-1];
    assign mem_rdata = pv[MEM_LAT-1] ? mdata(pa[MEM_LAT-1]) : 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic push_fill(input logic [15:0] addr);
        logic [15:0] a;
        for (int k = 0; k < BLK_WORDS; k++) begin
            a = {addr[15:4], 4'h0} + 16'(2 * k);
            exp_addr_q.push_back(a);
            exp_fill_q.push_back({3'(k), mdata(a)});
        end
    endtask

    // Scoreboard: pop expectations as the DUT produces accesses and fill words.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("grant_excl", {31'h0, i_grant & d_grant}, 32'h0);
            if (mem_en && !mem_wr) begin
                if (exp_addr_q.size() == 0) chk("rd_extra", 32'h1, 32'h0);
                else chk("rd_addr", {16'h0, mem_addr}, {16'h0, exp_addr_q.pop_front()});
            end
            if (mem_en && mem_wr) begin
                if (exp_wr_q.size() == 0) chk("wr_extra", 32'h1, 32'h0);
                else chk("wr_access", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
            end else begin
                chk("wdata_zero", {16'h0, mem_wdata}, 32'h0);
            end
            if (fill_vld) begin
                if (exp_fill_q.size() == 0) chk("fill_extra", 32'h1, 32'h0);
                else chk("fill_word", {13'h0, fill_idx, fill_data}, {13'h0, exp_fill_q.pop_front()});
            end
        end
    end

    task automatic wait_grant(input bit is_d, output int lat);
        bit found = 0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (is_d ? d_grant : i_grant) begin
                lat = n;
                found = 1;
                break;
            end
        end
        chk(is_d ? "d_grant_seen" : "i_grant_seen", {31'h0, found}, 32'h1);
    endtask

    task automatic wait_done(input bit is_d, input bit drop, output int lat);
        bit found = 0;
        bit held  = 1;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (is_d ? d_done : i_done) begin
                lat = n;
                found = 1;
                break;
            end
            if (!(is_d ? d_grant : i_grant)) held = 0;
        end
        if (drop) begin
            if (is_d) d_req = 1'b0;
            else i_req = 1'b0;
        end
        chk(is_d ? "d_done_seen" : "i_done_seen", {31'h0, found}, 32'h1);
        chk("grant_held", {31'h0, held}, 32'h1);
        chk("grant_drop_at_done", {30'h0, i_grant, d_grant}, 32'h0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {25'h0, i_grant, d_grant, i_done, d_done, fill_vld, mem_en, mem_wr}, 32'h0);
        chk({name, "_addr"}, {mem_addr, mem_wdata}, 32'h0);
        chk({name, "_fill"}, {13'h0, fill_idx, fill_data}, 32'h0);
    endtask

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int g;
        vecs[0] = '{is_d: 0, wr: 0, addr: 16'h0136, wdata: 16'h0000, lat: 12};
        vecs[1] = '{is_d: 1, wr: 1, addr: 16'h2002, wdata: 16'hBEEF, lat: 1};
        vecs[2] = '{is_d: 1, wr: 0, addr: 16'hFFFE, wdata: 16'h0000, lat: 12};
        vecs[3] = '{is_d: 0, wr: 0, addr: 16'h0000, wdata: 16'h0000, lat: 12};
        vecs[4] = '{is_d: 1, wr: 1, addr: 16'($urandom_range(0, 65535)),
                    wdata: 16'($urandom_range(0, 65535)), lat: 1};
        vecs[5] = '{is_d: 1, wr: 0, addr: 16'($urandom_range(0, 65535)), wdata: 16'h0, lat: 12};

        // Reset state
        repeat (3) tick();
        chk_all_zero("reset_outs");
        rst_n = 1'b1;
        tick();
        chk_all_zero("idle_outs");

        // Simultaneous I and D fill requests from reset: D first, then I.
        i_req = 1'b1; i_addr = 16'h1100;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2200;
        push_fill(16'h2200);
        push_fill(16'h1100);
        wait_grant(1, lat);
        chk("tie_d_first_lat", lat, 1);
        chk("tie_i_low", {31'h0, i_grant}, 32'h0);
        wait_done(1, 1, lat);
        chk("tie_d_done_lat", lat, 12);
        wait_grant(0, lat);
        chk("tie_i_after_d", lat, 1);
        wait_done(0, 1, lat);
        chk("tie_i_done_lat", lat, 12);
        tick();

        // D held continuously with I pending: D, I, D.
        d_req = 1'b1; d_addr = 16'h3000;
        i_req = 1'b1; i_addr = 16'h4000;
        push_fill(16'h3000);
        push_fill(16'h4000);
        push_fill(16'h3000);
        wait_grant(1, lat);
        chk("alt_d1_lat", lat, 1);
        wait_done(1, 0, lat);
        wait_grant(0, lat);
        chk("alt_i_lat", lat, 1);
        wait_done(0, 0, lat);
        wait_grant(1, lat);
        chk("alt_d2_lat", lat, 1);
        wait_done(1, 1, lat);
        i_req = 1'b0;
        tick();
        tick();
        chk("alt_quiet", {30'h0, i_grant, d_grant}, 32'h0);

        // Vector table of single transactions.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].is_d) begin
                d_req = 1'b1; d_wr = vecs[v].wr; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
            end else begin
                i_req = 1'b1; i_addr = vecs[v].addr;
            end
            if (vecs[v].wr) exp_wr_q.push_back({vecs[v].addr, vecs[v].wdata});
            else push_fill(vecs[v].addr);
            wait_grant(vecs[v].is_d, lat);
            chk("vec_grant_lat", lat, 1);
            chk("vec_other_grant", {31'h0, vecs[v].is_d ? i_grant : d_grant}, 32'h0);
            wait_done(vecs[v].is_d, 1, lat);
            chk("vec_done_lat", lat, vecs[v].lat);
            chk("vec_drain", exp_addr_q.size() + exp_fill_q.size() + exp_wr_q.size(), 0);
            d_wr = 1'b0; d_wdata = 16'h0;
            tick();
        end

        // Reset in the middle of an I fill; fill restarts at word 0.
        i_req = 1'b1; i_addr = 16'h0440;
        push_fill(16'h0440);
        wait_grant(0, lat);
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        exp_addr_q.delete();
        exp_fill_q.delete();
        exp_wr_q.delete();
        repeat (4) tick();
        rst_n = 1'b1;
        chk("no_done_after_reset", {31'h0, i_done}, 32'h0);
        push_fill(16'h0440);
        wait_grant(0, lat);
        chk("restart_grant_lat", lat, 1);
        wait_done(0, 1, lat);
        chk("restart_done_lat", lat, 12);
        chk("restart_drain", exp_addr_q.size() + exp_fill_q.size(), 0);
        tick();

        // Drop req and change address early: the latched block still completes.
        i_req = 1'b1; i_addr = 16'h1A2C;
        push_fill(16'h1A2C);
        wait_grant(0, lat);
        repeat (2) tick();
        i_req = 1'b0; i_addr = 16'hFFFE;
        wait_done(0, 0, lat);
        chk("drop_done_lat", lat, 10);
        chk("drop_drain", exp_addr_q.size() + exp_fill_q.size(), 0);
        g = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (i_grant || d_grant) g++;
        end
        chk("drop_no_regrant", g, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
